// File: rtl/mul_pkg.sv
// Shared types and parameter helpers for the Booth multiplier datapath.
package mul_pkg;

    localparam int MUL_W = 64;
    localparam int MUL_G = 4;
    localparam int MUL_N = 64;

    localparam int PP_ROWS = MUL_W / 2;
    localparam int GROUPS  = MUL_W / (2 * MUL_G);

    typedef enum logic [2:0] {B_ZERO, B_P1, B_P2, B_M1, B_M2} booth_digit_t;

    typedef enum logic [1:0] {S_IDLE, S_GEN, S_DONE} pp_state_t;

    function automatic bit params_ok(input int w, input int g, input int n);
        return (w >= 2) && (w % 2 == 0) && (g >= 1) && ((w / 2) % g == 0) && (n >= w / 2 + 1);
    endfunction

    function automatic booth_digit_t booth_decode(input logic [2:0] triplet);
        booth_digit_t d;
        case (triplet)
            3'b001, 3'b010: d = B_P1;
            3'b011:         d = B_P2;
            3'b100:         d = B_M2;
            3'b101, 3'b110: d = B_M1;
            default:        d = B_ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_pp_row.sv
// One radix-4 Booth partial product: digit times extended multiplicand, aligned to its row.
module booth_pp_row
    import mul_pkg::*;
#(
    parameter int W  = MUL_W,
    parameter int RW = 5
) (
    input  logic [2:0]     triplet,
    input  logic [2*W-1:0] a_ext,
    input  logic [RW-1:0]  row,
    output logic [2*W-1:0] slot
);

    booth_digit_t   digit;
    logic [2*W-1:0] mag;

    // Negative digits are fully negated here so every slot is a complete two's-complement value.
    always_comb begin
        digit = booth_decode(triplet);
        mag   = '0;
        case (digit)
            B_P1:    mag = a_ext;
            B_P2:    mag = a_ext << 1;
            B_M1:    mag = -a_ext;
            B_M2:    mag = -(a_ext << 1);
            default: mag = '0;
        endcase
        slot = mag << {row, 1'b0};
    end

endmodule

// File: rtl/booth_pp_gen.sv
// Sequential radix-4 Booth partial-product generator feeding adder_tree.
// state  | meaning
// S_IDLE | waiting for an operand pair, in_ready=1
// S_GEN  | writing G partial-product slots per cycle
// S_DONE | pp_bus complete, out_valid=1 until out_ready
module booth_pp_gen
    import mul_pkg::*;
#(
    parameter int W = MUL_W,
    parameter int G = MUL_G,
    parameter int N = MUL_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W*N-1:0] pp_bus
);

    localparam int SW   = 2 * W;
    localparam int ROWS = W / 2;
    localparam int NGRP = W / (2 * G);
    localparam int CW   = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;

    if (!params_ok(W, G, N)) begin : g_bad_params
        $error("booth_pp_gen: W must be even, G must divide W/2, N must be >= W/2+1");
    end

    pp_state_t       state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [SW-1:0]   a_ext_r;
    logic [W-1:0]    b_r;
    logic [SW*N-1:0] bus_r;
    logic [SW*N-1:0] bus_init;
    logic [SW-1:0]   a_ext_in;
    logic            accept;
    logic            gen_last;

    logic [W:0]      b_tri;
    logic [RW-1:0]   row_idx  [G];
    logic [SW-1:0]   row_slot [G];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        gen_last  = (cnt == CW'(NGRP - 1));
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = S_GEN;
                end
            end
            S_GEN: begin
                if (gen_last) state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Unsigned operands with b's top bit set need +a*2^W, since Booth reads b as signed.
    always_comb begin
        a_ext_in = in_signed ? {{W{in_a[W-1]}}, in_a} : {{W{1'b0}}, in_a};
        bus_init = '0;
        if (!in_signed && in_b[W-1]) begin
            bus_init[SW*ROWS +: SW] = {in_a, {W{1'b0}}};
        end
    end

    assign b_tri = {b_r, 1'b0};

    for (genvar k = 0; k < G; k++) begin : g_row
        logic [2:0] trip;
        assign row_idx[k] = RW'(int'(cnt) * G + k);
        assign trip       = b_tri[2*row_idx[k] +: 3];

        booth_pp_row #(
            .W  (W),
            .RW (RW)
        ) u_row (
            .triplet (trip),
            .a_ext   (a_ext_r),
            .row     (row_idx[k]),
            .slot    (row_slot[k])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_ext_r <= '0;
            b_r     <= '0;
            bus_r   <= '0;
            cnt     <= '0;
        end else if (accept) begin
            a_ext_r <= a_ext_in;
            b_r     <= in_b;
            bus_r   <= bus_init;
            cnt     <= '0;
        end else if (state == S_GEN) begin
            for (int k = 0; k < G; k++) begin
                bus_r[int'(row_idx[k])*SW +: SW] <= row_slot[k];
            end
            cnt <= gen_last ? '0 : cnt + 1'b1;
        end
    end

    assign pp_bus = bus_r;

endmodule

// File: tb/tb_booth_pp_gen.sv
// Self-checking bench for booth_pp_gen: directed cases plus random traffic against an arithmetic model.
module tb_booth_pp_gen;

    localparam int W  = 64;
    localparam int G  = 4;
    localparam int N  = 64;
    localparam int SW = 2 * W;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_a;
    logic [W-1:0]    in_b;
    logic            in_signed;
    logic            out_valid;
    logic            out_ready;
    logic [SW*N-1:0] pp_bus;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    booth_pp_gen #(.W(W), .G(G), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pp_bus    (pp_bus)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] ext(input logic [W-1:0] v, input logic s);
        return s ? {{W{v[W-1]}}, v} : {{W{1'b0}}, v};
    endfunction

    // Digit value from the Booth rule as plain arithmetic: -2*b[2i+1] + b[2i] + b[2i-1].
    function automatic logic [127:0] ref_slot(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic s, input int i);
        logic [W:0]   bx;
        logic [127:0] ae, dm, r;
        int           d;
        bx = {b, 1'b0};
        ae = ext(a, s);
        r  = '0;
        if (i < W / 2) begin
            d  = -2 * int'(bx[2*i+2]) + int'(bx[2*i+1]) + int'(bx[2*i]);
            dm = 128'(d);
            r  = (ae * dm) << (2 * i);
        end else if (i == W / 2) begin
            r = (!s && b[W-1]) ? (ae << W) : '0;
        end
        return r;
    endfunction

    function automatic logic [127:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic s);
        return ext(a, s) * ext(b, s);
    endfunction

    function automatic logic [127:0] slot_of(input int i);
        return pp_bus[i*SW +: SW];
    endfunction

    function automatic logic [127:0] bus_sum();
        logic [127:0] acc;
        acc = '0;
        for (int i = 0; i < N; i++) acc += slot_of(i);
        return acc;
    endfunction

    task automatic check_bus(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic s);
        int nbad;
        nbad = 0;
        for (int i = 0; i < N; i++) begin
            if (slot_of(i) !== ref_slot(a, b, s, i)) nbad++;
        end
        chk({tag, "_slots"}, nbad, 0);
        chk({tag, "_sum"}, bus_sum(), ref_prod(a, b, s));
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        @(negedge clk);
        in_a      = a;
        in_b      = b;
        in_signed = s;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    logic [W-1:0]    qa[$], qb[$];
    logic            qs[$];
    logic [SW*N-1:0] snap;
    int              cyc, ncyc, last_acc, ndone;
    logic [W-1:0]    ra, rb;
    logic            rs;
    logic [W-1:0]    corners [4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
                                     64'h7FFF_FFFF_FFFF_FFFF, 64'h0};

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_signed = 1'b0;
        out_ready = 1'b1;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_bus_zero", |pp_bus, 0);
        @(negedge clk);
        rst = 1'b0;

        // 3 * 5 signed
        start_op(64'd3, 64'd5, 1'b1);
        chk("t1_gen_in_ready", in_ready, 0);
        wait_out(cyc);
        chk("t1_latency", cyc, 8);
        chk("t1_slot0", slot_of(0), 128'd3);
        chk("t1_slot1", slot_of(1), 128'd12);
        chk("t1_total", bus_sum(), 128'd15);
        check_bus("t1", 64'd3, 64'd5, 1'b1);
        @(negedge clk);
        chk("t1_idle", in_ready, 1);

        // -1 * -1 signed
        start_op('1, '1, 1'b1);
        wait_out(cyc);
        chk("t2_latency", cyc, 8);
        chk("t2_slot0", slot_of(0), 128'd1);
        chk("t2_total", bus_sum(), 128'd1);
        check_bus("t2", '1, '1, 1'b1);
        @(negedge clk);

        // max * max unsigned
        start_op('1, '1, 1'b0);
        wait_out(cyc);
        chk("t3_latency", cyc, 8);
        chk("t3_slot32", slot_of(32), 128'hFFFFFFFFFFFFFFFF_0000000000000000);
        chk("t3_slot0", slot_of(0), 128'hFFFFFFFFFFFFFFFF_0000000000000001);
        chk("t3_total", bus_sum(), 128'hFFFFFFFFFFFFFFFE_0000000000000001);
        check_bus("t3", '1, '1, 1'b0);
        @(negedge clk);

        // backpressure with an ignored input pulse
        out_ready = 1'b0;
        start_op(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 1'b1);
        wait_out(cyc);
        chk("bp_latency", cyc, 8);
        snap = pp_bus;
        for (int j = 0; j < 5; j++) begin
            in_valid = (j == 1 || j == 2);
            in_a     = 64'd11;
            in_b     = 64'd13;
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_bus_stable", pp_bus === snap, 1);
            chk("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        check_bus("bp", 64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 1'b1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_idle", in_ready, 1);
        chk("bp_release_valid", out_valid, 0);
        repeat (3) @(negedge clk);
        chk("bp_no_accept", in_ready, 1);

        // reset while generating
        start_op(64'hDEAD_BEEF_0BAD_F00D, 64'h0123_4567_89AB_CDEF, 1'b0);
        repeat (4) @(negedge clk);
        chk("mid_bus_busy", |pp_bus, 1);
        rst = 1'b1;
        #1;
        chk("mid_out_valid", out_valid, 0);
        chk("mid_bus_zero", |pp_bus, 0);
        chk("mid_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        start_op(64'd7, -64'sd2, 1'b1);
        wait_out(cyc);
        chk("mid_latency", cyc, 8);
        chk("mid_total", bus_sum(), ~128'd13);
        check_bus("mid", 64'd7, -64'sd2, 1'b1);
        @(negedge clk);

        // random traffic, in_valid and out_ready held high
        in_valid = 1'b1;
        ncyc     = 0;
        last_acc = -1;
        ndone    = 0;
        while (ndone < 1000 && ncyc < 20000) begin
            if (out_valid) begin
                check_bus("rnd", qa.pop_front(), qb.pop_front(), qs.pop_front());
                ndone++;
            end
            if (in_ready) begin
                ra = ($urandom_range(7) == 0) ? corners[$urandom_range(3)] : {$urandom, $urandom};
                rb = ($urandom_range(7) == 0) ? corners[$urandom_range(3)] : {$urandom, $urandom};
                rs = 1'($urandom_range(1));
                in_a      = ra;
                in_b      = rb;
                in_signed = rs;
                qa.push_back(ra);
                qb.push_back(rb);
                qs.push_back(rs);
                if (last_acc >= 0) chk("rnd_interval", ncyc - last_acc, 10);
                last_acc = ncyc;
            end
            @(negedge clk);
            ncyc++;
        end
        in_valid = 1'b0;
        chk("rnd_ops_done", ndone, 1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
